// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the inter-stage pipeline latches.
//   - EX/MEM control-bundle field offsets and total width.
//   - NOP_CTRL, the all-zero bubble control word.
//   - slot_op_e, the per-cycle operation applied to one storage slot.
package pipe_pkg;

    // EX/MEM control bundle layout: {jal, lbu, syscall, mem[1:0], we, rw[4:0]}
    localparam int CTRL_W_EXMEM = 11;
    localparam int RW_LSB       = 0;
    localparam int RW_W         = 5;
    localparam int WE_BIT       = 5;
    localparam int MEM_LSB      = 6;
    localparam int MEM_W        = 2;
    localparam int SYSCALL_BIT  = 8;
    localparam int LBU_BIT      = 9;
    localparam int JAL_BIT      = 10;

    // A bubble: no register write, no memory access, no jump, no syscall.
    localparam logic [CTRL_W_EXMEM-1:0] NOP_CTRL = '0;

    typedef enum logic [1:0] {
        SLOT_HOLD  = 2'd0,  // keep contents
        SLOT_LOAD  = 2'd1,  // capture new entry, mark valid
        SLOT_CLEAR = 2'd2   // invalidate and zero ctrl; data left as is
    } slot_op_e;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one storage entry (valid + control + data) of a pipeline latch.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   op             HOLD / LOAD / CLEAR for this edge
//   ld_data/ctrl   entry captured on LOAD
//   valid/data/ctrl current slot contents
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_BITS = 96,
    parameter int CTRL_BITS = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  slot_op_e             op,
    input  logic [DATA_BITS-1:0] ld_data,
    input  logic [CTRL_BITS-1:0] ld_ctrl,
    output logic                 valid,
    output logic [DATA_BITS-1:0] data,
    output logic [CTRL_BITS-1:0] ctrl
);

    logic                 valid_q, valid_d;
    logic [DATA_BITS-1:0] data_q,  data_d;
    logic [CTRL_BITS-1:0] ctrl_q,  ctrl_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        unique case (op)
            SLOT_LOAD: begin
                valid_d = 1'b1;
                data_d  = ld_data;
                ctrl_d  = ld_ctrl;
            end
            // Stale data is kept on purpose: only ctrl can cause side effects downstream.
            SLOT_CLEAR: begin
                valid_d = 1'b0;
                ctrl_d  = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            // NOTE: the data payload is reset as well, so out_data reads a defined zero after reset.
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_latch.sv
// pipe_stage_latch: elastic valid/ready latch placed between two pipeline stages.
// Holds DATA_CH data channels plus a control bundle, with optional skid entry,
// flush-to-bubble and a saturating stall-cycle counter.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream handshake
//   in_data/in_ctrl          incoming entry (channel k at [k*DATA_W +: DATA_W])
//   flush                    squash held and incoming entries
//   out_valid/out_ready      downstream handshake
//   out_data/out_ctrl        head entry (out_ctrl is zero when out_valid=0)
//   stall_cycles             saturating count of out_valid & !out_ready cycles
module pipe_stage_latch
    import pipe_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DATA_CH     = 3,
    parameter int CTRL_W      = 11,
    parameter int SKID        = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_CH*DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_CH*DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [STALL_CNT_W-1:0]    stall_cycles
);

    localparam int DW = DATA_CH * DATA_W;

    logic              main_valid, skid_valid;
    logic [DW-1:0]     main_data,  skid_data;
    logic [CTRL_W-1:0] main_ctrl,  skid_ctrl;
    slot_op_e          main_op,    skid_op;
    logic              main_from_skid;
    logic              accept, pop;

    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    // With a skid entry, in_ready depends only on stored state, so there is
    // no combinational path from out_ready back upstream.
    always_comb begin
        if (SKID != 0) in_ready = !rst && !skid_valid;
        else           in_ready = !rst && (!main_valid || out_ready);
    end

    assign accept = in_valid && in_ready;
    assign pop    = main_valid && out_ready;

    always_comb begin
        main_op        = SLOT_HOLD;
        skid_op        = SLOT_HOLD;
        main_from_skid = 1'b0;
        if (flush) begin
            // Flush outranks accept and pop; an incoming entry is simply dropped.
            main_op = SLOT_CLEAR;
            skid_op = SLOT_CLEAR;
        end else if (SKID != 0) begin
            unique case ({accept, pop})
                2'b01: begin
                    if (skid_valid) begin
                        main_op        = SLOT_LOAD;
                        main_from_skid = 1'b1;
                        skid_op        = SLOT_CLEAR;
                    end else begin
                        main_op = SLOT_CLEAR;
                    end
                end
                2'b10: begin
                    if (!main_valid) main_op = SLOT_LOAD;
                    else             skid_op = SLOT_LOAD;
                end
                2'b11: begin
                    // Skid is older than the input, so it advances first.
                    main_op = SLOT_LOAD;
                    if (skid_valid) begin
                        main_from_skid = 1'b1;
                        skid_op        = SLOT_LOAD;
                    end
                end
                default: ;
            endcase
        end else begin
            if (accept)   main_op = SLOT_LOAD;
            else if (pop) main_op = SLOT_CLEAR;
        end
    end

    pipe_slot #(
        .DATA_BITS (DW),
        .CTRL_BITS (CTRL_W)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .op      (main_op),
        .ld_data (main_from_skid ? skid_data : in_data),
        .ld_ctrl (main_from_skid ? skid_ctrl : in_ctrl),
        .valid   (main_valid),
        .data    (main_data),
        .ctrl    (main_ctrl)
    );

    if (SKID != 0) begin : g_skid
        pipe_slot #(
            .DATA_BITS (DW),
            .CTRL_BITS (CTRL_W)
        ) u_skid (
            .clk     (clk),
            .rst     (rst),
            .op      (skid_op),
            .ld_data (in_data),
            .ld_ctrl (in_ctrl),
            .valid   (skid_valid),
            .data    (skid_data),
            .ctrl    (skid_ctrl)
        );
    end else begin : g_no_skid
        assign skid_valid = 1'b0;
        assign skid_data  = '0;
        assign skid_ctrl  = '0;
    end

    always_comb begin
        stall_d = stall_q;
        if (main_valid && !out_ready && !flush && (stall_q != '1))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign out_valid    = main_valid;
    assign out_data     = main_data;
    assign out_ctrl     = main_valid ? main_ctrl : '0;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_stage_latch.sv
// tb_pipe_stage_latch: directed bench for pipe_stage_latch.
// dut_a: SKID=1 with a 4-bit stall counter; dut_b: SKID=0 with defaults.
module tb_pipe_stage_latch;

    localparam int DW = 96;

    logic clk = 1'b0;
    logic rst;

    logic          a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [10:0]   a_in_ctrl, a_out_ctrl;
    logic [3:0]    a_stall;

    logic          b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [10:0]   b_in_ctrl, b_out_ctrl;
    logic [15:0]   b_stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_latch #(
        .DATA_W(32), .DATA_CH(3), .CTRL_W(11), .SKID(1), .STALL_CNT_W(4)
    ) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_ctrl(a_in_ctrl), .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_ctrl(a_out_ctrl), .stall_cycles(a_stall)
    );

    pipe_stage_latch #(
        .DATA_W(32), .DATA_CH(3), .CTRL_W(11), .SKID(0), .STALL_CNT_W(16)
    ) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_ctrl(b_in_ctrl), .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_ctrl(b_out_ctrl), .stall_cycles(b_stall)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Settle point: 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [DW-1:0] mk(input int k);
        return {32'(k * 256), 32'(k), 32'(32'h1000 + 4 * k)};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_in_ctrl = '0; a_flush = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_ctrl = '0; b_flush = 1'b0; b_out_ready = 1'b0;

        // ---------------- reset then idle ----------------
        tick();
        check("a_in_ready_in_rst", a_in_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        check("a_rst_in_ready", a_in_ready, 1);
        check("a_rst_out_valid", a_out_valid, 0);
        check("a_rst_out_ctrl", a_out_ctrl, 0);
        check("a_rst_out_data", a_out_data, 0);
        check("a_rst_stall", a_stall, 0);
        check("b_rst_out_valid", b_out_valid, 0);
        check("b_rst_in_ready", b_in_ready, 1);

        // ---------------- streaming (SKID=1) ----------------
        a_out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            a_in_valid = 1'b1;
            a_in_ctrl  = 11'(k);
            a_in_data  = mk(k);
            #1;
            check("stream_in_ready", a_in_ready, 1);
            tick();
            check("stream_out_valid", a_out_valid, 1);
            check("stream_out_ctrl", a_out_ctrl, 11'(k));
            check("stream_out_data", a_out_data, mk(k));
        end
        a_in_valid = 1'b0;
        tick();
        check("stream_drain_valid", a_out_valid, 0);
        check("stream_drain_ctrl", a_out_ctrl, 0);
        check("stream_stall", a_stall, 0);

        // ---------------- backpressure (SKID=1) ----------------
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_ctrl = 11'(33); a_in_data = mk(33);   // A
        tick();
        check("bp_a_ctrl", a_out_ctrl, 11'(33));
        check("bp_a_stall", a_stall, 0);
        a_in_ctrl = 11'(34); a_in_data = mk(34);                       // B
        #1;
        check("bp_b_in_ready", a_in_ready, 1);
        tick();
        check("bp_hold_a_ctrl", a_out_ctrl, 11'(33));
        check("bp_stall1", a_stall, 1);
        a_in_ctrl = 11'(35); a_in_data = mk(35);                       // C
        #1;
        check("bp_full_in_ready", a_in_ready, 0);
        tick();
        tick();
        check("bp_hold_a_data", a_out_data, mk(33));
        check("bp_hold_a_ctrl2", a_out_ctrl, 11'(33));
        check("bp_stall3", a_stall, 3);
        a_out_ready = 1'b1;
        tick();
        check("bp_out_b", a_out_ctrl, 11'(34));
        check("bp_out_b_data", a_out_data, mk(34));
        check("bp_ready_after_pop", a_in_ready, 1);
        tick();
        check("bp_out_c", a_out_ctrl, 11'(35));
        check("bp_out_c_data", a_out_data, mk(35));
        a_in_valid = 1'b0;
        tick();
        check("bp_drain_valid", a_out_valid, 0);
        check("bp_stall_final", a_stall, 3);

        // ---------------- flush (SKID=1) ----------------
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_ctrl = 11'(36); a_in_data = mk(36);   // D -> main
        tick();
        a_in_ctrl = 11'(37); a_in_data = mk(37);                       // E -> skid
        tick();
        check("fl_full_stall", a_stall, 4);
        a_in_ctrl = 11'(38); a_in_data = mk(38);                       // F offered
        a_flush = 1'b1;
        #1;
        check("fl_full_in_ready", a_in_ready, 0);
        tick();
        check("fl_full_out_valid", a_out_valid, 0);
        check("fl_full_out_ctrl", a_out_ctrl, 0);
        check("fl_full_stall_kept", a_stall, 4);
        a_flush = 1'b0;
        a_in_ctrl = 11'(39); a_in_data = mk(39);                       // G -> main
        #1;
        check("fl_g_in_ready", a_in_ready, 1);
        tick();
        check("fl_g_ctrl", a_out_ctrl, 11'(39));
        a_in_ctrl = 11'(40); a_in_data = mk(40);                       // H with flush
        a_flush = 1'b1;
        #1;
        check("fl_h_in_ready", a_in_ready, 1);
        tick();
        check("fl_h_out_valid", a_out_valid, 0);
        check("fl_h_out_ctrl", a_out_ctrl, 0);
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        tick();
        check("fl_nothing_valid", a_out_valid, 0);
        tick();
        check("fl_nothing_valid2", a_out_valid, 0);
        a_in_valid = 1'b1; a_in_ctrl = 11'(41); a_in_data = mk(41);   // I
        tick();
        check("fl_i_valid", a_out_valid, 1);
        check("fl_i_ctrl", a_out_ctrl, 11'(41));
        check("fl_i_data", a_out_data, mk(41));
        check("fl_stall", a_stall, 4);
        a_in_valid = 1'b0;
        tick();

        // ---------------- stall saturation (4-bit) ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("sat_rst_stall", a_stall, 0);
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_ctrl = 11'(42); a_in_data = mk(42);   // J
        tick();
        a_in_valid = 1'b0;
        check("sat_start", a_stall, 0);
        repeat (15) tick();
        check("sat_at_15", a_stall, 4'hF);
        repeat (5) tick();
        check("sat_stays_15", a_stall, 4'hF);
        check("sat_held_ctrl", a_out_ctrl, 11'(42));
        check("sat_held_data", a_out_data, mk(42));

        // ---------------- reset beats flush, mid-stall ----------------
        rst = 1'b1; a_flush = 1'b1;
        tick();
        rst = 1'b0; a_flush = 1'b0;
        check("rst_mid_valid", a_out_valid, 0);
        check("rst_mid_ctrl", a_out_ctrl, 0);
        check("rst_mid_stall", a_stall, 0);

        // ---------------- SKID=0 throughput ----------------
        for (int i = 0; i <= 6; i++) begin
            b_out_ready = (i % 2 == 0);
            b_in_valid  = 1'b1;
            b_in_ctrl   = 11'((i + 1) / 2 + 1);
            b_in_data   = mk((i + 1) / 2 + 1);
            #1;
            check("s0_in_ready", b_in_ready, (i % 2 == 0) ? 1 : 0);
            tick();
            check("s0_out_valid", b_out_valid, 1);
            check("s0_out_ctrl", b_out_ctrl, 11'(i / 2 + 1));
            check("s0_out_data", b_out_data, mk(i / 2 + 1));
        end
        check("s0_stall", b_stall, 3);
        b_in_ctrl = 11'(5); b_in_data = mk(5);
        b_flush = 1'b1;
        #1;
        check("s0_flush_in_ready", b_in_ready, 1);
        tick();
        check("s0_flush_valid", b_out_valid, 0);
        check("s0_flush_ctrl", b_out_ctrl, 0);
        b_flush = 1'b0; b_in_valid = 1'b0;
        tick();
        check("s0_after_flush_valid", b_out_valid, 0);
        b_in_valid = 1'b1; b_in_ctrl = 11'(6); b_in_data = mk(6);
        tick();
        check("s0_next_ctrl", b_out_ctrl, 11'(6));
        check("s0_next_data", b_out_data, mk(6));
        b_in_valid = 1'b0;
        tick();
        check("s0_drain_valid", b_out_valid, 0);
        check("s0_stall_final", b_stall, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
